// File: rtl/soc_mem_pkg.sv
// Shared constants for the SRAM responder: config window base, register offsets,
// and the read-data value returned for unmapped or fetch-side config accesses.
package soc_mem_pkg;

    localparam logic [31:0] CONF_BASE_DEFAULT = 32'hBFAF_0000;

    typedef enum logic [15:0] {
        CONF_LED    = 16'h0000,
        CONF_NUM    = 16'h0004,
        CONF_TIMER  = 16'h0008,
        CONF_SWITCH = 16'h000C
    } conf_off_e;

    localparam logic [31:0] RDATA_ZERO = '0;

endpackage

// File: rtl/soc_conf_regs.sv
// Memory-mapped board registers: LED, NUM, free-running TIMER and read-only SWITCH.
// Writes are full-word only; the caller qualifies 'we' with the window hit and we==4'hF.
module soc_conf_regs
    import soc_mem_pkg::*;
#(
    parameter int unsigned TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [15:0] offset,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch_in,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [31:0] num
);

    logic [TIMER_W-1:0] timer;
    logic [15:0]        wdata_hi_unused;

    // LED/NUM hold unless written; TIMER counts every cycle, a write replaces the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            led   <= '0;
            num   <= '0;
            timer <= '0;
        end else begin
            if (we && offset == CONF_LED) led <= wdata[15:0];
            if (we && offset == CONF_NUM) num <= wdata;
            if (we && offset == CONF_TIMER) timer <= wdata[TIMER_W-1:0];
            else                            timer <= timer + TIMER_W'(1);
        end
    end

    // Read mux over current register values; unmapped offsets read zero
    always_comb begin
        rdata = RDATA_ZERO;
        case (offset)
            CONF_LED:    rdata = {16'h0000, led};
            CONF_NUM:    rdata = num;
            CONF_TIMER:  rdata[TIMER_W-1:0] = timer;
            CONF_SWITCH: rdata = {24'h000000, switch_in};
            default:     rdata = RDATA_ZERO;
        endcase
    end

    always_comb wdata_hi_unused = wdata[31:16];

endmodule

// File: rtl/soc_sram_responder.sv
// Responder for the CPU fetch and load/store ports: one word RAM (two read ports,
// byte-enabled write from the data port) plus the config register window.
// Fixed one-cycle read latency; RAM reads are read-first against a same-cycle store.
module soc_sram_responder
    import soc_mem_pkg::*;
#(
    parameter int unsigned RAM_AW    = 14,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT,
    parameter int unsigned TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] inst_idx;
    logic [RAM_AW-1:0] data_idx;
    logic              inst_conf;
    logic              data_conf;
    logic              conf_we;
    logic [31:0]       conf_rdata;
    logic              unused_bits;

    // Address decode: window hit on the upper half-word, otherwise RAM with upper bits aliased
    always_comb begin
        inst_conf   = inst_sram_addr[31:16] == CONF_BASE[31:16];
        data_conf   = data_sram_addr[31:16] == CONF_BASE[31:16];
        inst_idx    = inst_sram_addr[RAM_AW+1:2];
        data_idx    = data_sram_addr[RAM_AW+1:2];
        conf_we     = data_sram_en && data_conf && (data_sram_we == 4'hF);
        unused_bits = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr, data_sram_addr};
    end

    soc_conf_regs #(
        .TIMER_W (TIMER_W)
    ) u_conf (
        .clk       (clk),
        .reset     (reset),
        .we        (conf_we),
        .offset    (data_sram_addr[15:0]),
        .wdata     (data_sram_wdata),
        .switch_in (switch_in),
        .rdata     (conf_rdata),
        .led       (led_out),
        .num       (num_out)
    );

    // Byte-lane RAM write from the data port; requests during reset are dropped
    always_ff @(posedge clk) begin
        if (!reset && data_sram_en && !data_conf) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram_we[i]) ram[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Registered read data; holds when idle, and the data port also holds on stores
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_rdata <= RDATA_ZERO;
            data_sram_rdata <= RDATA_ZERO;
        end else begin
            if (inst_sram_en) inst_sram_rdata <= inst_conf ? RDATA_ZERO : ram[inst_idx];
            if (data_sram_en && data_sram_we == 4'h0)
                data_sram_rdata <= data_conf ? conf_rdata : ram[data_idx];
        end
    end

endmodule

// File: tb/tb_soc_sram_responder.sv
// Scoreboard bench for soc_sram_responder: stimulus pushes expected responses
// tagged with the cycle they are due; a monitor on the falling edge pops and compares.
module tb_soc_sram_responder;

    localparam int K_INST = 0;
    localparam int K_DATA = 1;
    localparam int K_LED  = 2;
    localparam int K_NUM  = 3;

    typedef struct {
        int          due;
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    soc_sram_responder #(
        .RAM_AW    (14),
        .CONF_BASE (32'hBFAF_0000),
        .TIMER_W   (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .num_out         (num_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_INST:  act = inst_sram_rdata;
                K_DATA:  act = data_sram_rdata;
                K_LED:   act = {16'h0000, led_out};
                default: act = num_out;
            endcase
            n_tests++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL %s missed due cycle %0d (now %0d) actual=%h expected=%h",
                         e.name, e.due, cyc, act, e.exp);
            end else if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
            end
        end
    end

    // Drive one request cycle on the falling edge
    task automatic req(input logic rst, input logic ien, input logic [31:0] ia,
                       input logic den, input logic [3:0] dwe, input logic [31:0] da,
                       input logic [31:0] dw);
        @(negedge clk);
        reset           = rst;
        inst_sram_en    = ien;
        inst_sram_addr  = ia;
        inst_sram_we    = 4'hF;
        inst_sram_wdata = 32'hFFFF_FFFF;
        data_sram_en    = den;
        data_sram_we    = dwe;
        data_sram_addr  = da;
        data_sram_wdata = dw;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Expect a value one cycle after the request just driven
    task automatic expect_next(input int kind, input string name, input logic [31:0] v);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    initial begin
        switch_in = 8'h00;
        req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_next(K_INST, "reset_inst", 32'h0);
        expect_next(K_DATA, "reset_data", 32'h0);
        expect_next(K_LED,  "reset_led",  32'h0);
        expect_next(K_NUM,  "reset_num",  32'h0);

        // Preload words used later
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0200, 32'h0000_0000);

        // Requests during reset are dropped
        req(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0010, 32'h1111_1111);
        req(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_FFFF);
        expect_next(K_LED, "reset_led_write_dropped", 32'h0);
        req(1'b1, 1'b1, 32'h0000_0010, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        expect_next(K_INST, "reset_fetch_dropped", 32'h0);
        expect_next(K_DATA, "reset_load_dropped", 32'h0);
        req(1'b0, 1'b1, 32'h0000_0010, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        expect_next(K_INST, "ram4_kept_inst", 32'hCAFE_F00D);
        expect_next(K_DATA, "ram4_kept_data", 32'hCAFE_F00D);

        // Byte-lane writes
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        expect_next(K_DATA, "byte_merge", 32'h11BB_33DD);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0300, 32'h5555_AAAA);
        expect_next(K_DATA, "store_holds_rdata", 32'h11BB_33DD);
        idle();
        expect_next(K_INST, "idle_holds_inst", 32'hCAFE_F00D);

        // Read-first on a same-cycle store
        req(1'b0, 1'b1, 32'h0000_0200, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
        expect_next(K_INST, "read_first_old", 32'h0);
        req(1'b0, 1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_next(K_INST, "read_after_write", 32'hDEAD_BEEF);

        // Config registers
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_A5A5);
        expect_next(K_LED, "led_write", 32'h0000_A5A5);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'hBFAF_0000, 32'h0000_1234);
        expect_next(K_LED, "led_partial_ignored", 32'h0000_A5A5);
        switch_in = 8'h3C;
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
        expect_next(K_DATA, "switch_read", 32'h0000_003C);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0004, 32'h8765_4321);
        expect_next(K_NUM, "num_write", 32'h8765_4321);
        req(1'b0, 1'b1, 32'hBFAF_0000, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        expect_next(K_DATA, "num_read", 32'h8765_4321);
        expect_next(K_INST, "fetch_conf_zero", 32'h0);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0010, 32'h7777_7777);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
        expect_next(K_DATA, "unmapped_read_zero", 32'h0);
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        expect_next(K_DATA, "led_read", 32'h0000_A5A5);

        // Timer load and wrap
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
        idle();
        req(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        expect_next(K_DATA, "timer_max", 32'hFFFF_FFFF);
        req(1'b0, 1'b1, 32'hBFAF_0008, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        expect_next(K_DATA, "timer_wrap", 32'h0);
        expect_next(K_INST, "fetch_timer_zero", 32'h0);

        // Address aliasing above the RAM index bits
        req(1'b0, 1'b1, 32'h0000_0010, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678);
        req(1'b0, 1'b1, 32'h0004_0040, 1'b1, 4'h0, 32'h0004_0040, 32'h0);
        expect_next(K_DATA, "alias_data", 32'h1234_5678);
        expect_next(K_INST, "alias_inst", 32'h1234_5678);

        idle();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s never checked actual=none expected=%h", e.name, e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
